stage_memory_store: RTL
=======================

Name: stage_memory_store

Overview:
Memory-stage store unit for the RV32I pipeline; the write-side counterpart of the memory load stage.
- Takes the effective address, rs2 data and store funct3 from the pipeline.
- Drives a word-aligned address, lane-shifted write data and byte enables to data memory.
- Holds the pipeline until the configured write latency has elapsed, then pulses is_complete.

Parameters:
WRITE_LATENCY, 1, cycles from the write-issue cycle to the is_complete cycle; legal range 1..7.

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
enable  input  1  a store instruction occupies the stage; inputs held stable while high
i_effective_addr  input  XLEN  byte address, rs1 + imm
i_store_data  input  XLEN  rs2 value
i_funct3  input  3  store width: 000 SB, 001 SH, 010 SW
is_complete  output  1  one-cycle pulse; store finished, pipeline may advance
mem_addr  output  XLEN  {i_effective_addr[XLEN-1:2], 2'b00}
mem_w_data  output  XLEN  lane-replicated store data
mem_w_byte_en  output  4  byte lane enables, bit n = byte n
mem_w_enable  output  1  write strobe, memory samples on posedge
store_misaligned  output  1  present only with MISALIGNED_STORE_TRAP_EN

Behaviour:
Lane formatting (combinational, always driven from current inputs):
- SB: data = {4{rs2[7:0]}}; byte_en = 4'b0001 << addr[1:0].
- SH: data = {2{rs2[15:0]}}; byte_en = addr[1] ? 4'b1100 : 4'b0011.
- SW: data = rs2; byte_en = 4'b1111.
- Any other funct3: byte_en = 4'b0000; no write is issued.

State machine, 2 states, plus counter remaining (width $clog2(WRITE_LATENCY+1)):
- IDLE:
  - mem_w_enable = enable && valid_funct3.
  - If mem_w_enable: go to WAIT, remaining <= WRITE_LATENCY-1.
  - If enable && !valid_funct3: is_complete=1 this cycle, no write, stay IDLE.
- WAIT:
  - mem_w_enable = 0.
  - If !enable: abort to IDLE, no is_complete; the issued write is not retracted.
  - Else if remaining==0: is_complete=1, next state IDLE.
  - Else: remaining decrements.

Timing and boundary conditions:
- Latency: issue at cycle N, is_complete at cycle N+WRITE_LATENCY. Exactly one write strobe per store.
- Back-to-back: enable held high across two stores. The cycle after is_complete is IDLE and issues the next store immediately. No double write of the first store.
- Reset: state IDLE, remaining 0, is_complete 0, mem_w_enable 0. Reset mid-WAIT abandons the store.
- Misaligned addresses without the macro: SH ignores addr[0]; SW ignores addr[1:0]; SB is always aligned.
- is_complete and mem_w_enable are never high in the same cycle, except via the optional trap path, which has no write.

Optional Feature:
MISALIGNED_STORE_TRAP_EN
- Defined:
  - Adds the store_misaligned port, high when enable && ((SH && addr[0]) || (SW && addr[1:0]!=0)).
  - On misalignment in IDLE: no write is issued, and is_complete plus store_misaligned pulse the same cycle.
  - store_misaligned resets to 0.
- Undefined: port absent; truncation behaviour as above.

Decomposition:
- Shared isa_constants package holds:
  - XLEN.
  - Store funct3 encodings FUNCT3_SB/SH/SW.
  - typedef enum store_state_t {STORE_IDLE, STORE_WAIT}.
- One natural sub-module: store_lane_formatter, combinational; inputs funct3, addr[1:0], rs2; outputs w_data, byte_en, valid, misaligned.

Test Plan:
1. SW addr 0x1000, data 0xDEADBEEF, WRITE_LATENCY=1 -> cycle0: mem_w_enable=1, mem_addr=0x1000, byte_en=1111; cycle1: is_complete=1.
2. SB addr 0x2003, data 0x000000A5 -> byte_en=1000, mem_w_data=0xA5A5A5A5, mem_addr=0x2000; one strobe only.
3. SH addr 0x2002, data 0x1234; WRITE_LATENCY=3 -> byte_en=1100, data=0x12341234; is_complete exactly at cycle 3 after issue.
4. Two SWs back-to-back with enable held high -> two strobes at cycles 0 and 2, is_complete at cycles 1 and 3.
5. enable dropped in WAIT (latency 3), then reset asserted mid-store -> no is_complete; all outputs 0, state IDLE.
6. With MISALIGNED_STORE_TRAP_EN: SW addr 0x1002 -> store_misaligned=1, is_complete=1, mem_w_enable=0 same cycle. Without the macro: write to 0x1000 with byte_en 1111.

Source files
------------

// File: rtl/isa_constants.sv
// Shared RV32I constants for the pipeline: datapath width, store funct3
// encodings and the store-stage state type.
package isa_constants;

  localparam int XLEN = 32;

  localparam logic [2:0] FUNCT3_SB = 3'b000;
  localparam logic [2:0] FUNCT3_SH = 3'b001;
  localparam logic [2:0] FUNCT3_SW = 3'b010;

  typedef enum logic {
    STORE_IDLE = 1'b0,
    STORE_WAIT = 1'b1
  } store_state_t;

endpackage

// File: rtl/store_lane_formatter.sv
// Combinational store lane formatter: replicates rs2 across the byte lanes
// and produces byte enables for SB/SH/SW. Misaligned halfwords and words are
// truncated to their natural boundary here; the misaligned flag lets the
// parent decide whether to trap instead.
module store_lane_formatter
  import isa_constants::*;
(
  input  logic [2:0]      funct3_i,
  input  logic [1:0]      addr_lo_i,
  input  logic [XLEN-1:0] rs2_i,
  output logic [XLEN-1:0] w_data_o,
  output logic [3:0]      byte_en_o,
  output logic            valid_o,
  output logic            misaligned_o
);

  // Decode store width into lane data, byte enables and alignment status
  always_comb begin
    w_data_o     = rs2_i;
    byte_en_o    = 4'b0000;
    valid_o      = 1'b0;
    misaligned_o = 1'b0;
    case (funct3_i)
      FUNCT3_SB: begin
        w_data_o  = {4{rs2_i[7:0]}};
        byte_en_o = 4'b0001 << addr_lo_i;
        valid_o   = 1'b1;
      end
      FUNCT3_SH: begin
        w_data_o     = {2{rs2_i[15:0]}};
        byte_en_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        valid_o      = 1'b1;
        misaligned_o = addr_lo_i[0];
      end
      FUNCT3_SW: begin
        w_data_o     = rs2_i;
        byte_en_o    = 4'b1111;
        valid_o      = 1'b1;
        misaligned_o = (addr_lo_i != 2'b00);
      end
      default: begin
        w_data_o  = rs2_i;
        byte_en_o = 4'b0000;
      end
    endcase
  end

endmodule

// File: rtl/stage_memory_store.sv
// Memory-stage store unit for the RV32I pipeline. Issues one write strobe per
// store, then holds the pipeline for WRITE_LATENCY cycles before pulsing
// is_complete. Unknown funct3 completes immediately without writing.
// Optional macro MISALIGNED_STORE_TRAP_EN adds the store_misaligned port and
// turns misaligned SH/SW into a no-write trap instead of address truncation.
module stage_memory_store
  import isa_constants::*;
#(
  parameter int WRITE_LATENCY = 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            enable,
  input  logic [XLEN-1:0] i_effective_addr,
  input  logic [XLEN-1:0] i_store_data,
  input  logic [2:0]      i_funct3,
  output logic            is_complete,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_w_data,
  output logic [3:0]      mem_w_byte_en,
  output logic            mem_w_enable
`ifdef MISALIGNED_STORE_TRAP_EN
  ,
  output logic            store_misaligned
`endif
);

  localparam int CNT_W = $clog2(WRITE_LATENCY + 1);
  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(WRITE_LATENCY - 1);

`ifdef MISALIGNED_STORE_TRAP_EN
  localparam bit TRAP_ENABLED = 1'b1;
`else
  localparam bit TRAP_ENABLED = 1'b0;
`endif

  store_state_t     state_q, state_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;

  logic fmtValid;
  logic fmtMisaligned;
  logic trapStore;
  logic writeIssue;
  logic storeDone;

  store_lane_formatter u_formatter (
    .funct3_i     (i_funct3),
    .addr_lo_i    (i_effective_addr[1:0]),
    .rs2_i        (i_store_data),
    .w_data_o     (mem_w_data),
    .byte_en_o    (mem_w_byte_en),
    .valid_o      (fmtValid),
    .misaligned_o (fmtMisaligned)
  );

  assign trapStore = TRAP_ENABLED && fmtMisaligned;
  assign mem_addr  = {i_effective_addr[XLEN-1:2], 2'b00};

  // Next-state, latency countdown and strobe/complete generation
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    writeIssue  = 1'b0;
    storeDone   = 1'b0;
    if (!reset) begin
      case (state_q)
        STORE_IDLE: begin
          if (enable) begin
            if (fmtValid && !trapStore) begin
              writeIssue  = 1'b1;
              state_d     = STORE_WAIT;
              remaining_d = LAST_COUNT;
            end else begin
              storeDone = 1'b1;
            end
          end
        end
        STORE_WAIT: begin
          if (!enable) begin
            state_d = STORE_IDLE;
          end else if (remaining_q == '0) begin
            storeDone = 1'b1;
            state_d   = STORE_IDLE;
          end else begin
            remaining_d = remaining_q - 1'b1;
          end
        end
        default: state_d = STORE_IDLE;
      endcase
    end
  end

  // State and countdown registers; reset abandons any store in flight
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= STORE_IDLE;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
    end
  end

  assign mem_w_enable = writeIssue;
  assign is_complete  = storeDone;

`ifdef MISALIGNED_STORE_TRAP_EN
  assign store_misaligned = !reset && (state_q == STORE_IDLE) && enable &&
                            fmtValid && fmtMisaligned;
`endif

endmodule
